adc_frame_align: RTL and testbench



---
 rtl/adc_frame_align.sv | 167 ++++++++++++++++
 tb/tb_adc_frame_align.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_align.sv
// Frame-lane alignment controller. It issues bitslip pulses to the frame and data deserializers
// until the frame word matches FrmPattern. Define ADC_FRAME_LOCK_MONITOR_EN to keep watching the word after lock.
module adc_frame_align #(
  parameter int unsigned AdcBits      = 14,
  parameter logic [15:0] FrmPattern   = 16'h3F80,
  parameter int unsigned SettleCycles = 4,
  parameter int unsigned ConfirmCount = 4,
  parameter int unsigned MaxSlips     = 14
) (
  input  logic        FrmClkDiv,
  input  logic        FrmRst,
  input  logic [15:0] FrmData,
  input  logic        AlignStart,
  output logic        FrmBitslip,
  output logic        FrmAlignDone,
  output logic        FrmAlignErr,
  output logic [4:0]  SlipCount
);

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_CHECK,
    ST_CONFIRM,
    ST_SLIP,
    ST_DONE,
    ST_FAIL
  } state_e;

  localparam logic [3:0] SettleLast = 4'(SettleCycles - 1);
  localparam logic [3:0] ConfirmN   = 4'(ConfirmCount);
  localparam logic [4:0] SlipLimit  = 5'(MaxSlips);

  state_e     state_q, state_d;
  logic [3:0] settle_q, settle_d;
  logic [3:0] match_q, match_d;
  logic [4:0] slip_q, slip_d;
  logic       bitslip_q, done_q, err_q;
`ifdef ADC_FRAME_LOCK_MONITOR_EN
  logic [1:0] miss_q, miss_d;
`endif

  logic [AdcBits-1:0] bit_eq;
  logic               frm_match;
  logic               unused_upper;

  for (genvar gi = 0; gi < AdcBits; gi++) begin : g_cmp
    assign bit_eq[gi] = (FrmData[gi] == FrmPattern[gi]);
  end
  assign frm_match    = &bit_eq;
  assign unused_upper = ^FrmData[15:AdcBits];

  // Outcome of a failed compare, shared by CHECK and CONFIRM.
  state_e     miss_state;
  logic [4:0] miss_slips;
  always_comb begin
    if (slip_q == SlipLimit) begin
      miss_state = ST_FAIL;
      miss_slips = slip_q;
    end else begin
      miss_state = ST_SLIP;
      miss_slips = (slip_q == 5'd31) ? slip_q : slip_q + 5'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    match_d  = match_q;
    slip_d   = slip_q;
`ifdef ADC_FRAME_LOCK_MONITOR_EN
    miss_d   = miss_q;
`endif
    case (state_q)
      ST_SETTLE: begin
        if (settle_q == SettleLast) begin
          settle_d = '0;
          state_d  = ST_CHECK;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_CHECK: begin
        if (frm_match) begin
          match_d = 4'd1;
          state_d = (ConfirmN == 4'd1) ? ST_DONE : ST_CONFIRM;
        end else begin
          state_d = miss_state;
          slip_d  = miss_slips;
        end
      end
      ST_CONFIRM: begin
        if (frm_match) begin
          match_d = match_q + 4'd1;
          if (match_q + 4'd1 == ConfirmN) state_d = ST_DONE;
        end else begin
          match_d = '0;
          state_d = miss_state;
          slip_d  = miss_slips;
        end
      end
      ST_SLIP: begin
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_DONE: begin
`ifdef ADC_FRAME_LOCK_MONITOR_EN
        if (frm_match) begin
          miss_d = '0;
        end else if (miss_q == 2'd2) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
          match_d  = '0;
          slip_d   = '0;
          miss_d   = '0;
        end else begin
          miss_d = miss_q + 2'd1;
        end
`endif
      end
      default: begin
      end
    endcase

    // Restart overrides every state; a SLIP pulse already on the output still completes.
    if (AlignStart) begin
      state_d  = ST_SETTLE;
      settle_d = '0;
      match_d  = '0;
      slip_d   = '0;
`ifdef ADC_FRAME_LOCK_MONITOR_EN
      miss_d   = '0;
`endif
    end
  end

  always_ff @(posedge FrmClkDiv) begin
    if (FrmRst) begin
      state_q   <= ST_SETTLE;
      settle_q  <= '0;
      match_q   <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef ADC_FRAME_LOCK_MONITOR_EN
      miss_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      match_q   <= match_d;
      slip_q    <= slip_d;
      bitslip_q <= (state_d == ST_SLIP);
      done_q    <= (state_d == ST_DONE);
      err_q     <= (state_d == ST_FAIL);
`ifdef ADC_FRAME_LOCK_MONITOR_EN
      miss_q    <= miss_d;
`endif
    end
  end

  assign FrmBitslip   = bitslip_q;
  assign FrmAlignDone = done_q;
  assign FrmAlignErr  = err_q;
  assign SlipCount    = slip_q;

endmodule

// File: tb/tb_adc_frame_align.sv
// Directed bench for adc_frame_align with a rotating-word deserializer model.
// Expectations for the post-lock scenario follow ADC_FRAME_LOCK_MONITOR_EN.
`timescale 1ns/1ps
module tb_adc_frame_align;

  logic        FrmClkDiv = 1'b0;
  logic        FrmRst = 1'b1;
  logic [15:0] FrmData = 16'h0000;
  logic        AlignStart = 1'b0;
  logic        FrmBitslip;
  logic        FrmAlignDone;
  logic        FrmAlignErr;
  logic [4:0]  SlipCount;

  int pass_cnt = 0;
  int check_cnt = 0;

  int          mis = 0;
  bit          use_model = 1'b0;
  bit          force_bad = 1'b0;
  logic [15:0] const_data = 16'h3F80;
  int          cyc = 0;
  int          pulses = 0;
  int          last_pulse = -1;
  int          min_gap = 1000;
  int          n;

  always #5 FrmClkDiv = ~FrmClkDiv;

  adc_frame_align dut (
    .FrmClkDiv   (FrmClkDiv),
    .FrmRst      (FrmRst),
    .FrmData     (FrmData),
    .AlignStart  (AlignStart),
    .FrmBitslip  (FrmBitslip),
    .FrmAlignDone(FrmAlignDone),
    .FrmAlignErr (FrmAlignErr),
    .SlipCount   (SlipCount)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Frame word seen by the deserializer when it is mis positions away from alignment.
  function automatic logic [15:0] model_word(input int m);
    logic [13:0] p;
    logic [27:0] d;
    p = 14'h3F80;
    d = {p, p} << m;
    return {2'b10, d[27:14]};
  endfunction

  task automatic step();
    @(posedge FrmClkDiv);
    #1;
    cyc++;
    if (FrmBitslip === 1'b1) begin
      pulses++;
      if (last_pulse >= 0 && (cyc - last_pulse - 1) < min_gap) min_gap = cyc - last_pulse - 1;
      last_pulse = cyc;
      mis = (mis + 13) % 14;
    end
    if (force_bad) FrmData = 16'h0000;
    else if (use_model) FrmData = model_word(mis);
    else FrmData = const_data;
  endtask

  task automatic clear_stats();
    pulses = 0;
    last_pulse = -1;
    min_gap = 1000;
  endtask

  task automatic do_reset(input string tag);
    FrmRst = 1'b1;
    AlignStart = 1'b0;
    step();
    step();
    check_val({tag, "_rst_bitslip"}, FrmBitslip, 0);
    check_val({tag, "_rst_done"}, FrmAlignDone, 0);
    check_val({tag, "_rst_err"}, FrmAlignErr, 0);
    check_val({tag, "_rst_slips"}, SlipCount, 0);
    FrmRst = 1'b0;
    clear_stats();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // 1: aligned from reset release, lock on the 8th edge
    use_model = 1'b0;
    const_data = 16'h3F80;
    FrmData = const_data;
    do_reset("t1");
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) check_val("t1_done_early", FrmAlignDone, 0);
    end
    check_val("t1_done", FrmAlignDone, 1);
    check_val("t1_pulses", pulses, 0);
    check_val("t1_slips", SlipCount, 0);
    check_val("t1_err", FrmAlignErr, 0);
    $display("scenario 1: aligned input, done=%0d slips=%0d", FrmAlignDone, SlipCount);

    // 2: three positions off, model rotates on each pulse
    use_model = 1'b1;
    do_reset("t2");
    mis = 3;
    n = 0;
    while (FrmAlignDone !== 1'b1 && n < 300) begin step(); n++; end
    check_val("t2_done", FrmAlignDone, 1);
    check_val("t2_pulses", pulses, 3);
    check_val("t2_slips", SlipCount, 3);
    check_val("t2_gap_ge5", (min_gap >= 5), 1);
    check_val("t2_err", FrmAlignErr, 0);
    $display("scenario 2: offset 3, pulses=%0d min_gap=%0d", pulses, min_gap);

    // 3: never matches -> fail after 14 slips, then restart
    use_model = 1'b0;
    const_data = 16'h0000;
    do_reset("t3");
    n = 0;
    while (FrmAlignErr !== 1'b1 && n < 400) begin step(); n++; end
    check_val("t3_err", FrmAlignErr, 1);
    check_val("t3_done", FrmAlignDone, 0);
    check_val("t3_pulses", pulses, 14);
    check_val("t3_slips", SlipCount, 14);
    check_val("t3_gap_ge5", (min_gap >= 5), 1);
    repeat (10) step();
    check_val("t3_err_held", FrmAlignErr, 1);
    check_val("t3_pulses_held", pulses, 14);
    AlignStart = 1'b1;
    step();
    AlignStart = 1'b0;
    check_val("t3_restart_err", FrmAlignErr, 0);
    check_val("t3_restart_slips", SlipCount, 0);
    clear_stats();
    n = 0;
    while (FrmBitslip !== 1'b1 && n < 50) begin step(); n++; end
    check_val("t3_resume_delay", n, 5);
    $display("scenario 3: fail then restart, first new pulse after %0d cycles", n);

    // 4: one corrupt word during CONFIRM (upper bits set throughout)
    const_data = 16'hFF80;
    do_reset("t4");
    for (int i = 1; i <= 15; i++) begin
      step();
      if (i == 5) FrmData = 16'hFF81;
      if (i == 6) check_val("t4_slip", FrmBitslip, 1);
      if (i == 8) check_val("t4_no_early_done", FrmAlignDone, 0);
      if (i == 14) check_val("t4_done_late", FrmAlignDone, 0);
    end
    check_val("t4_done", FrmAlignDone, 1);
    check_val("t4_pulses", pulses, 1);
    check_val("t4_slips", SlipCount, 1);
    $display("scenario 4: corrupt confirm word, pulses=%0d done=%0d", pulses, FrmAlignDone);

    // 5: restart coinciding with SLIP, then reset together with restart
    const_data = 16'h0000;
    do_reset("t5");
    n = 0;
    while (FrmBitslip !== 1'b1 && n < 50) begin step(); n++; end
    check_val("t5_first_slip", n, 5);
    check_val("t5_slips_in_slip", SlipCount, 1);
    AlignStart = 1'b1;
    step();
    check_val("t5_pulse_ended", FrmBitslip, 0);
    check_val("t5_restart_slips", SlipCount, 0);
    check_val("t5_one_pulse", pulses, 1);
    FrmRst = 1'b1;
    step();
    check_val("t5_rst_bitslip", FrmBitslip, 0);
    check_val("t5_rst_done", FrmAlignDone, 0);
    check_val("t5_rst_err", FrmAlignErr, 0);
    check_val("t5_rst_slips", SlipCount, 0);
    FrmRst = 1'b0;
    clear_stats();
    repeat (12) step();
    check_val("t5_hold_pulses", pulses, 0);
    check_val("t5_hold_slips", SlipCount, 0);
    AlignStart = 1'b0;
    n = 0;
    while (FrmBitslip !== 1'b1 && n < 50) begin step(); n++; end
    check_val("t5_release_slip", n, 5);
    $display("scenario 5: restart during slip, reset with restart, hold");

    // 6: bad words after lock
    use_model = 1'b1;
    do_reset("t6");
    mis = 2;
    n = 0;
    while (FrmAlignDone !== 1'b1 && n < 300) begin step(); n++; end
    check_val("t6_locked", FrmAlignDone, 1);
    check_val("t6_locked_slips", SlipCount, 2);
    force_bad = 1'b1;
    FrmData = 16'h0000;
    step();
    force_bad = 1'b0;
    step();
    check_val("t6_two_bad", FrmAlignDone, 1);
    step();
    step();
    check_val("t6_two_bad_after", FrmAlignDone, 1);
    force_bad = 1'b1;
    FrmData = 16'h0000;
    step();
    step();
    check_val("t6_two_of_three", FrmAlignDone, 1);
    force_bad = 1'b0;
    step();
`ifdef ADC_FRAME_LOCK_MONITOR_EN
    check_val("t6_three_bad_drop", FrmAlignDone, 0);
    check_val("t6_three_bad_slips", SlipCount, 0);
    n = 0;
    while (FrmAlignDone !== 1'b1 && n < 50) begin step(); n++; end
    check_val("t6_relock_delay", n, 8);
`else
    check_val("t6_three_bad_hold", FrmAlignDone, 1);
    check_val("t6_three_bad_slips", SlipCount, 2);
    repeat (5) step();
    check_val("t6_still_done", FrmAlignDone, 1);
`endif
    $display("scenario 6: post-lock bad words, done=%0d slips=%0d", FrmAlignDone, SlipCount);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
